spi_cmd_rx: RTL and testbench

- SPI slave command receiver, in the 48 MHz CLK domain, directly upstream of wcm.
- Deserialises MCU frames into one real-time command record (FREQ … Tblank2) or a system-time preset (TIME_INIT).
- Validates each frame with a checksum.
- Updates its held outputs atomically, then pulses SPI_WR (record frames) or SYS_TIME_UPDATE (time frames) toward wcm / master_start.

---
 rtl/spi_cmd_rx.sv | 248 ++++++++++++++++++++++++
 tb/tb_spi_cmd_rx.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_rx.sv
// SPI mode-0 slave that deserialises checksummed command frames into a held
// real-time record or a system-time preset, then strobes SPI_WR or SYS_TIME_UPDATE.
module spi_cmd_rx #(
  parameter int unsigned WR_LEN   = 4,
  parameter logic [7:0]  CMD_REC  = 8'h01,
  parameter logic [7:0]  CMD_TIME = 8'h02
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic        SPI_SCK,
  input  logic        SPI_CS_n,
  input  logic        SPI_MOSI,
  output logic        SPI_MISO,
  input  logic        SYS_TIME_UPDATE_OK,
  output logic [47:0] FREQ,
  output logic [47:0] FREQ_STEP,
  output logic [31:0] FREQ_RATE,
  output logic [63:0] TIME_START,
  output logic [15:0] N_impulse,
  output logic [1:0]  TYPE_impulse,
  output logic [31:0] Interval_Ti,
  output logic [31:0] Interval_Tp,
  output logic [31:0] Tblank1,
  output logic [31:0] Tblank2,
  output logic        SPI_WR,
  output logic [63:0] TIME_INIT,
  output logic        SYS_TIME_UPDATE,
  output logic        ERR
);

  localparam int unsigned REC_BYTES  = 43;
  localparam int unsigned TIME_BYTES = 8;
  localparam int unsigned SHADOW_W   = REC_BYTES * 8;
  localparam logic [7:0]  PULSE_LAST = 8'(WR_LEN - 1);

  typedef enum logic [2:0] {
    IDLE, CMD, PAYLOAD, SUM, CHECK, COMMIT, PULSE, DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          sck_sync_q, cs_sync_q;
  logic [1:0]          mosi_sync_q;
  logic                rise_q, mosi_bit_q;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [6:0]          shift_q, shift_d;
  logic [5:0]          byte_cnt_q, byte_cnt_d, len_q, len_d;
  logic                is_rec_q, is_rec_d;
  logic [7:0]          sum_q, sum_d, rx_sum_q, rx_sum_d;
  logic [7:0]          status_q, status_d, pulse_cnt_q, pulse_cnt_d;
  logic [SHADOW_W-1:0] shadow_q, shadow_d;
  logic                err_q, err_d, spi_wr_q, spi_wr_d, upd_q, upd_d;
  logic                commit_rec, commit_time;
  logic [47:0]         freq_q, freq_step_q;
  logic [31:0]         freq_rate_q, ti_q, tp_q, tb1_q, tb2_q;
  logic [63:0]         time_start_q, time_init_q;
  logic [15:0]         n_imp_q;
  logic [1:0]          type_q;

  logic sck_rise, sck_fall, cs_fall, cs_rise, cs_high, byte_done, busy;
  logic [7:0] byte_val;

  // Index 0 is the metastability flop, 1 the synced level, 2 its history.
  assign sck_rise  = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall  = ~sck_sync_q[1] & sck_sync_q[2];
  assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
  assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
  assign cs_high   = cs_sync_q[1];
  assign byte_done = rise_q && (bit_cnt_q == 3'd7);
  assign byte_val  = {shift_q, mosi_bit_q};
  assign busy      = (state_q != IDLE) && (state_q != CMD);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_cnt_d  = byte_cnt_q;
    len_d       = len_q;
    is_rec_d    = is_rec_q;
    sum_d       = sum_q;
    rx_sum_d    = rx_sum_q;
    status_d    = status_q;
    pulse_cnt_d = pulse_cnt_q;
    shadow_d    = shadow_q;
    err_d       = err_q;
    commit_rec  = 1'b0;
    commit_time = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d    = CMD;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = 6'd0;
          status_d   = {5'b0, SYS_TIME_UPDATE_OK, err_q, busy};
        end
      end
      CMD, PAYLOAD, SUM: begin
        if (cs_rise) begin
          state_d   = IDLE;
          err_d     = 1'b1;
          bit_cnt_d = 3'd0;
        end else begin
          if ((state_q == CMD) && sck_fall) status_d = {status_q[6:0], 1'b0};
          if (rise_q) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {shift_q[5:0], mosi_bit_q};
          end
          if (byte_done) begin
            if (state_q == CMD) begin
              sum_d = byte_val;
              if (byte_val == CMD_REC) begin
                state_d  = PAYLOAD;
                is_rec_d = 1'b1;
                len_d    = 6'(REC_BYTES);
              end else if (byte_val == CMD_TIME) begin
                state_d  = PAYLOAD;
                is_rec_d = 1'b0;
                len_d    = 6'(TIME_BYTES);
              end else begin
                state_d = DRAIN;
                err_d   = 1'b1;
              end
            end else if (state_q == PAYLOAD) begin
              shadow_d   = {shadow_q[SHADOW_W-9:0], byte_val};
              sum_d      = sum_q + byte_val;
              byte_cnt_d = byte_cnt_q + 6'd1;
              if (byte_cnt_q == len_q - 6'd1) state_d = SUM;
            end else begin
              rx_sum_d = byte_val;
              state_d  = CHECK;
            end
          end
        end
      end
      CHECK: begin
        // The output copy is registered here so the new values are visible in COMMIT.
        if (rx_sum_q == sum_q) begin
          state_d     = COMMIT;
          commit_rec  = is_rec_q;
          commit_time = ~is_rec_q;
          err_d       = 1'b0;
        end else begin
          state_d = DRAIN;
          err_d   = 1'b1;
        end
      end
      COMMIT: begin
        state_d     = PULSE;
        pulse_cnt_d = 8'd0;
      end
      PULSE: begin
        pulse_cnt_d = pulse_cnt_q + 8'd1;
        if (pulse_cnt_q == PULSE_LAST) state_d = DRAIN;
      end
      DRAIN: begin
        if (cs_high) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    spi_wr_d = (state_d == PULSE) && is_rec_q;
    upd_d    = (state_d == PULSE) && !is_rec_q;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sck_sync_q   <= 3'b000;
      cs_sync_q    <= 3'b111;
      mosi_sync_q  <= 2'b00;
      rise_q       <= 1'b0;
      mosi_bit_q   <= 1'b0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 7'd0;
      byte_cnt_q   <= 6'd0;
      len_q        <= 6'd0;
      is_rec_q     <= 1'b0;
      sum_q        <= 8'd0;
      rx_sum_q     <= 8'd0;
      status_q     <= 8'd0;
      pulse_cnt_q  <= 8'd0;
      shadow_q     <= '0;
      err_q        <= 1'b0;
      spi_wr_q     <= 1'b0;
      upd_q        <= 1'b0;
      freq_q       <= '0;
      freq_step_q  <= '0;
      freq_rate_q  <= '0;
      time_start_q <= '0;
      n_imp_q      <= '0;
      type_q       <= '0;
      ti_q         <= '0;
      tp_q         <= '0;
      tb1_q        <= '0;
      tb2_q        <= '0;
      time_init_q  <= '0;
    end else begin
      state_q     <= state_d;
      sck_sync_q  <= {sck_sync_q[1:0], SPI_SCK};
      cs_sync_q   <= {cs_sync_q[1:0], SPI_CS_n};
      mosi_sync_q <= {mosi_sync_q[0], SPI_MOSI};
      rise_q      <= sck_rise;
      mosi_bit_q  <= mosi_sync_q[1];
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      byte_cnt_q  <= byte_cnt_d;
      len_q       <= len_d;
      is_rec_q    <= is_rec_d;
      sum_q       <= sum_d;
      rx_sum_q    <= rx_sum_d;
      status_q    <= status_d;
      pulse_cnt_q <= pulse_cnt_d;
      shadow_q    <= shadow_d;
      err_q       <= err_d;
      spi_wr_q    <= spi_wr_d;
      upd_q       <= upd_d;
      // Record bytes were shifted in first-byte-first, so byte 0 sits at the top.
      if (commit_rec) begin
        freq_q       <= shadow_q[343:296];
        freq_step_q  <= shadow_q[295:248];
        freq_rate_q  <= shadow_q[247:216];
        time_start_q <= shadow_q[215:152];
        n_imp_q      <= shadow_q[151:136];
        type_q       <= shadow_q[129:128];
        ti_q         <= shadow_q[127:96];
        tp_q         <= shadow_q[95:64];
        tb1_q        <= shadow_q[63:32];
        tb2_q        <= shadow_q[31:0];
      end
      if (commit_time) time_init_q <= shadow_q[63:0];
    end
  end

  assign SPI_MISO        = (state_q == CMD) & status_q[7];
  assign FREQ            = freq_q;
  assign FREQ_STEP       = freq_step_q;
  assign FREQ_RATE       = freq_rate_q;
  assign TIME_START      = time_start_q;
  assign N_impulse       = n_imp_q;
  assign TYPE_impulse    = type_q;
  assign Interval_Ti     = ti_q;
  assign Interval_Tp     = tp_q;
  assign Tblank1         = tb1_q;
  assign Tblank2         = tb2_q;
  assign SPI_WR          = spi_wr_q;
  assign TIME_INIT       = time_init_q;
  assign SYS_TIME_UPDATE = upd_q;
  assign ERR             = err_q;

endmodule

// File: tb/tb_spi_cmd_rx.sv
// Randomised bench for spi_cmd_rx: frames are built from field values, the
// expected held outputs come from a small frame-level model.
`timescale 1ns/1ps
module tb_spi_cmd_rx;

  typedef struct packed {
    logic [47:0] freq;
    logic [47:0] step;
    logic [31:0] rate;
    logic [63:0] tstart;
    logic [15:0] n;
    logic [1:0]  typ;
    logic [31:0] ti;
    logic [31:0] tp;
    logic [31:0] tb1;
    logic [31:0] tb2;
  } rec_t;

  logic CLK = 1'b0;
  logic rst_n, SPI_SCK, SPI_CS_n, SPI_MOSI, SYS_TIME_UPDATE_OK;
  logic SPI_MISO, SPI_WR, SYS_TIME_UPDATE, ERR;
  logic [47:0] FREQ, FREQ_STEP;
  logic [31:0] FREQ_RATE, Interval_Ti, Interval_Tp, Tblank1, Tblank2;
  logic [63:0] TIME_START, TIME_INIT;
  logic [15:0] N_impulse;
  logic [1:0]  TYPE_impulse;

  spi_cmd_rx dut (
    .CLK(CLK), .rst_n(rst_n), .SPI_SCK(SPI_SCK), .SPI_CS_n(SPI_CS_n),
    .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO), .SYS_TIME_UPDATE_OK(SYS_TIME_UPDATE_OK),
    .FREQ(FREQ), .FREQ_STEP(FREQ_STEP), .FREQ_RATE(FREQ_RATE), .TIME_START(TIME_START),
    .N_impulse(N_impulse), .TYPE_impulse(TYPE_impulse), .Interval_Ti(Interval_Ti),
    .Interval_Tp(Interval_Tp), .Tblank1(Tblank1), .Tblank2(Tblank2), .SPI_WR(SPI_WR),
    .TIME_INIT(TIME_INIT), .SYS_TIME_UPDATE(SYS_TIME_UPDATE), .ERR(ERR)
  );

  always #10 CLK = ~CLK;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  rec_t dut_rec;
  assign dut_rec = {FREQ, FREQ_STEP, FREQ_RATE, TIME_START, N_impulse, TYPE_impulse,
                    Interval_Ti, Interval_Tp, Tblank1, Tblank2};

  // Pulse monitor: counts strobes, their widths and the record seen just before SPI_WR rose.
  int   wr_pulses = 0, wr_len = 0, wr_run = 0, wr_rise_cyc = 0;
  int   upd_pulses = 0, upd_len = 0, upd_run = 0, upd_rise_cyc = 0;
  int   both_high = 0;
  logic wr_prev = 1'b0, upd_prev = 1'b0;
  rec_t rec_prev = '0, rec_at_wr = '0;

  always @(negedge CLK) begin
    if (SPI_WR && !wr_prev) begin
      wr_rise_cyc <= cyc;
      rec_at_wr   <= rec_prev;
      wr_run      <= 1;
    end else if (SPI_WR) begin
      wr_run <= wr_run + 1;
    end
    if (!SPI_WR && wr_prev) begin
      wr_pulses <= wr_pulses + 1;
      wr_len    <= wr_run;
    end
    if (SYS_TIME_UPDATE && !upd_prev) begin
      upd_rise_cyc <= cyc;
      upd_run      <= 1;
    end else if (SYS_TIME_UPDATE) begin
      upd_run <= upd_run + 1;
    end
    if (!SYS_TIME_UPDATE && upd_prev) begin
      upd_pulses <= upd_pulses + 1;
      upd_len    <= upd_run;
    end
    if (SPI_WR && SYS_TIME_UPDATE) both_high <= both_high + 1;
    rec_prev <= dut_rec;
    wr_prev  <= SPI_WR;
    upd_prev <= SYS_TIME_UPDATE;
  end

  // Reference model state: what the held outputs should be after each frame.
  rec_t        exp_rec = '0;
  logic [63:0] exp_time = '0;
  logic        exp_err = 1'b0;
  logic [7:0]  frame_q[$];

  function automatic rec_t rand_rec();
    rec_t r;
    r.freq   = 48'({$urandom(), $urandom()});
    r.step   = 48'({$urandom(), $urandom()});
    r.rate   = $urandom();
    r.tstart = {$urandom(), $urandom()};
    r.n      = 16'($urandom());
    r.typ    = 2'($urandom());
    r.ti     = $urandom();
    r.tp     = $urandom();
    r.tb1    = $urandom();
    r.tb2    = $urandom();
    return r;
  endfunction

  task automatic push_be(input logic [63:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) frame_q.push_back(8'(v >> (8 * k)));
  endtask

  task automatic build_record(input rec_t r, input logic [5:0] type_pad);
    frame_q.delete();
    frame_q.push_back(8'h01);
    push_be(64'(r.freq), 6);
    push_be(64'(r.step), 6);
    push_be(64'(r.rate), 4);
    push_be(r.tstart, 8);
    push_be(64'(r.n), 2);
    frame_q.push_back({type_pad, r.typ});
    push_be(64'(r.ti), 4);
    push_be(64'(r.tp), 4);
    push_be(64'(r.tb1), 4);
    push_be(64'(r.tb2), 4);
  endtask

  task automatic build_time(input logic [63:0] t);
    frame_q.delete();
    frame_q.push_back(8'h02);
    push_be(t, 8);
  endtask

  task automatic append_checksum(input int delta);
    int s;
    s = 0;
    foreach (frame_q[i]) s += int'(frame_q[i]);
    frame_q.push_back(8'(s + delta));
  endtask

  // SCK period is 8 CLK cycles; MOSI changes while SCK is low, MISO sampled just before the rise.
  task automatic send_frame(input int n_send, input int chk_idx,
                            output logic [7:0] miso_byte, output int chk_rise);
    logic [7:0] b;
    miso_byte = 8'h00;
    chk_rise  = 0;
    SPI_CS_n  = 1'b0;
    repeat (8) @(negedge CLK);
    for (int i = 0; i < n_send; i++) begin
      b = frame_q[i];
      for (int j = 7; j >= 0; j--) begin
        SPI_MOSI = b[j];
        repeat (4) @(negedge CLK);
        if (i == 0) miso_byte[j] = SPI_MISO;
        SPI_SCK = 1'b1;
        if (i == chk_idx && j == 0) chk_rise = cyc;
        repeat (4) @(negedge CLK);
        SPI_SCK = 1'b0;
      end
    end
    repeat (4) @(negedge CLK);
    SPI_CS_n = 1'b1;
    repeat (30) @(negedge CLK);
    $display("[TB] frame cmd=%02h sent %0d of %0d bytes, miso=%02h", frame_q[0], n_send,
             frame_q.size(), miso_byte);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; SPI_CS_n = 1'b1; SPI_SCK = 1'b0; SPI_MOSI = 1'b0; SYS_TIME_UPDATE_OK = 1'b0;
    repeat (5) @(negedge CLK);
    tests_run++;
    if (dut_rec !== rec_t'(0)) begin tests_failed++; $display("FAIL reset_rec: got %h want 0", dut_rec); end
    tests_run++;
    if (TIME_INIT !== 64'd0) begin tests_failed++; $display("FAIL reset_time: got %h want 0", TIME_INIT); end
    tests_run++;
    if ({SPI_WR, SYS_TIME_UPDATE, ERR, SPI_MISO} !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_flags: got %b want 0000", {SPI_WR, SYS_TIME_UPDATE, ERR, SPI_MISO});
    end
    rst_n = 1'b1;
    repeat (5) @(negedge CLK);
  endtask

  task automatic test_record_basic();
    rec_t r;
    logic [7:0] miso;
    int rise, wr0, upd0;
    r.freq = 48'h280000000000; r.step = 48'h2CBD3F; r.rate = 32'd1; r.tstart = 64'd480000;
    r.n = 16'd10; r.typ = 2'd0; r.ti = 32'd4800; r.tp = 32'd4800; r.tb1 = 32'd480; r.tb2 = 32'd480;
    build_record(r, 6'd0);
    append_checksum(0);
    wr0 = wr_pulses; upd0 = upd_pulses;
    send_frame(frame_q.size(), frame_q.size() - 1, miso, rise);
    exp_rec = r; exp_err = 1'b0;
    tests_run++;
    if (wr_pulses - wr0 !== 1) begin tests_failed++; $display("FAIL rec_pulse_count: got %0d want 1", wr_pulses - wr0); end
    tests_run++;
    if (rec_at_wr !== exp_rec) begin tests_failed++; $display("FAIL rec_before_wr: got %h want %h", rec_at_wr, exp_rec); end
    tests_run++;
    if (wr_len !== 4) begin tests_failed++; $display("FAIL rec_wr_len: got %0d want 4", wr_len); end
    tests_run++;
    if (wr_rise_cyc - rise !== 6) begin tests_failed++; $display("FAIL rec_latency: got %0d want 6", wr_rise_cyc - rise); end
    tests_run++;
    if (ERR !== 1'b0) begin tests_failed++; $display("FAIL rec_err: got %b want 0", ERR); end
    tests_run++;
    if (upd_pulses !== upd0) begin tests_failed++; $display("FAIL rec_no_upd: got %0d want %0d", upd_pulses, upd0); end
  endtask

  task automatic test_time_frame();
    logic [7:0] miso;
    int rise, wr0, upd0;
    build_time(64'd1000);
    append_checksum(0);
    wr0 = wr_pulses; upd0 = upd_pulses;
    send_frame(frame_q.size(), frame_q.size() - 1, miso, rise);
    exp_time = 64'd1000;
    tests_run++;
    if (TIME_INIT !== exp_time) begin tests_failed++; $display("FAIL time_value: got %0d want %0d", TIME_INIT, exp_time); end
    tests_run++;
    if (upd_pulses - upd0 !== 1 || upd_len !== 4) begin
      tests_failed++; $display("FAIL time_pulse: got count %0d len %0d want 1/4", upd_pulses - upd0, upd_len);
    end
    tests_run++;
    if (upd_rise_cyc - rise !== 6) begin tests_failed++; $display("FAIL time_latency: got %0d want 6", upd_rise_cyc - rise); end
    tests_run++;
    if (wr_pulses !== wr0) begin tests_failed++; $display("FAIL time_no_wr: got %0d want %0d", wr_pulses, wr0); end
    tests_run++;
    if (dut_rec !== exp_rec) begin tests_failed++; $display("FAIL time_rec_hold: got %h want %h", dut_rec, exp_rec); end
  endtask

  task automatic good_record_check(input string tag);
    rec_t r;
    logic [7:0] miso;
    int rise, wr0;
    r = rand_rec();
    build_record(r, 6'($urandom()));
    append_checksum(0);
    wr0 = wr_pulses;
    send_frame(frame_q.size(), frame_q.size() - 1, miso, rise);
    exp_rec = r; exp_err = 1'b0;
    tests_run++;
    if (wr_pulses - wr0 !== 1 || dut_rec !== exp_rec) begin
      tests_failed++; $display("FAIL %s_recover: pulses %0d rec %h want 1 rec %h", tag, wr_pulses - wr0, dut_rec, exp_rec);
    end
    tests_run++;
    if (ERR !== exp_err) begin tests_failed++; $display("FAIL %s_err_clear: got %b want %b", tag, ERR, exp_err); end
  endtask

  task automatic test_bad_checksum();
    logic [7:0] miso;
    int rise, wr0;
    build_record(rand_rec(), 6'd0);
    append_checksum(1);
    wr0 = wr_pulses;
    send_frame(frame_q.size(), frame_q.size() - 1, miso, rise);
    exp_err = 1'b1;
    tests_run++;
    if (wr_pulses !== wr0) begin tests_failed++; $display("FAIL badsum_no_wr: got %0d want %0d", wr_pulses, wr0); end
    tests_run++;
    if (dut_rec !== exp_rec) begin tests_failed++; $display("FAIL badsum_hold: got %h want %h", dut_rec, exp_rec); end
    tests_run++;
    if (ERR !== exp_err) begin tests_failed++; $display("FAIL badsum_err: got %b want 1", ERR); end
    good_record_check("badsum");
  endtask

  task automatic test_abort();
    logic [7:0] miso;
    int rise, wr0;
    build_record(rand_rec(), 6'd0);
    append_checksum(0);
    wr0 = wr_pulses;
    send_frame(21, -1, miso, rise);
    exp_err = 1'b1;
    tests_run++;
    if (wr_pulses !== wr0 || dut_rec !== exp_rec) begin
      tests_failed++; $display("FAIL abort_hold: pulses %0d rec %h want 0 rec %h", wr_pulses - wr0, dut_rec, exp_rec);
    end
    tests_run++;
    if (ERR !== exp_err) begin tests_failed++; $display("FAIL abort_err: got %b want 1", ERR); end
    good_record_check("abort");
  endtask

  task automatic test_unknown_and_status();
    logic [7:0] miso, exp_status;
    logic [63:0] t;
    int rise, wr0, upd0;
    frame_q.delete();
    frame_q.push_back(8'h55);
    for (int i = 0; i < 44; i++) frame_q.push_back(8'($urandom()));
    wr0 = wr_pulses; upd0 = upd_pulses;
    send_frame(frame_q.size(), -1, miso, rise);
    exp_err = 1'b1;
    tests_run++;
    if (wr_pulses !== wr0 || upd_pulses !== upd0 || dut_rec !== exp_rec || TIME_INIT !== exp_time) begin
      tests_failed++; $display("FAIL unknown_hold: rec %h time %h want rec %h time %h", dut_rec, TIME_INIT, exp_rec, exp_time);
    end
    tests_run++;
    if (ERR !== exp_err) begin tests_failed++; $display("FAIL unknown_err: got %b want 1", ERR); end
    SYS_TIME_UPDATE_OK = 1'b1;
    exp_status = {5'b0, 1'b1, exp_err, 1'b0};
    t = {$urandom(), $urandom()};
    build_time(t);
    append_checksum(0);
    send_frame(frame_q.size(), frame_q.size() - 1, miso, rise);
    SYS_TIME_UPDATE_OK = 1'b0;
    exp_time = t; exp_err = 1'b0;
    tests_run++;
    if (miso !== exp_status) begin tests_failed++; $display("FAIL status_byte: got %02h want %02h", miso, exp_status); end
    tests_run++;
    if (TIME_INIT !== exp_time || ERR !== exp_err) begin
      tests_failed++; $display("FAIL status_frame_commit: time %h err %b want %h %b", TIME_INIT, ERR, exp_time, exp_err);
    end
  endtask

  task automatic test_trailing_bytes();
    rec_t r;
    logic [7:0] miso;
    int rise, wr0;
    r = rand_rec();
    build_record(r, 6'd0);
    append_checksum(0);
    for (int i = 0; i < 3; i++) frame_q.push_back(8'($urandom()));
    wr0 = wr_pulses;
    send_frame(frame_q.size(), frame_q.size() - 4, miso, rise);
    exp_rec = r;
    tests_run++;
    if (wr_pulses - wr0 !== 1 || dut_rec !== exp_rec) begin
      tests_failed++; $display("FAIL trailing: pulses %0d rec %h want 1 rec %h", wr_pulses - wr0, dut_rec, exp_rec);
    end
  endtask

  task automatic test_random_frames();
    rec_t r;
    logic [63:0] t;
    logic [7:0] miso;
    int rise, wr0, upd0, delta, exp_wr, exp_upd;
    bit is_rec;
    for (int it = 0; it < 6; it++) begin
      is_rec = 1'($urandom_range(0, 1));
      delta  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 255)) : 0;
      r = rand_rec();
      t = {$urandom(), $urandom()};
      if (is_rec) build_record(r, 6'($urandom())); else build_time(t);
      append_checksum(delta);
      wr0 = wr_pulses; upd0 = upd_pulses;
      send_frame(frame_q.size(), frame_q.size() - 1, miso, rise);
      exp_wr = 0; exp_upd = 0;
      if (delta == 0) begin
        if (is_rec) begin exp_rec = r; exp_wr = 1; end
        else begin exp_time = t; exp_upd = 1; end
        exp_err = 1'b0;
      end else begin
        exp_err = 1'b1;
      end
      tests_run++;
      if (dut_rec !== exp_rec || TIME_INIT !== exp_time) begin
        tests_failed++; $display("FAIL random_%0d_outputs: rec %h time %h want rec %h time %h", it, dut_rec, TIME_INIT, exp_rec, exp_time);
      end
      tests_run++;
      if (ERR !== exp_err || wr_pulses - wr0 !== exp_wr || upd_pulses - upd0 !== exp_upd) begin
        tests_failed++; $display("FAIL random_%0d_flags: err %b wr %0d upd %0d want %b %0d %0d", it, ERR,
                                 wr_pulses - wr0, upd_pulses - upd0, exp_err, exp_wr, exp_upd);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] miso;
    logic [63:0] t;
    int rise, upd0;
    build_record(rand_rec(), 6'd0);
    append_checksum(0);
    fork
      send_frame(frame_q.size(), -1, miso, rise);
      begin
        repeat (1200) @(negedge CLK);
        #3 rst_n = 1'b0;
        #1;
        tests_run++;
        if (dut_rec !== rec_t'(0)) begin tests_failed++; $display("FAIL areset_rec: got %h want 0", dut_rec); end
        tests_run++;
        if (TIME_INIT !== 64'd0) begin tests_failed++; $display("FAIL areset_time: got %h want 0", TIME_INIT); end
        tests_run++;
        if ({ERR, SPI_WR, SYS_TIME_UPDATE} !== 3'b000) begin
          tests_failed++; $display("FAIL areset_flags: got %b want 000", {ERR, SPI_WR, SYS_TIME_UPDATE});
        end
      end
    join
    @(negedge CLK);
    rst_n = 1'b1;
    exp_rec = '0; exp_time = '0; exp_err = 1'b0;
    repeat (5) @(negedge CLK);
    t = {$urandom(), $urandom()};
    build_time(t);
    append_checksum(0);
    upd0 = upd_pulses;
    send_frame(frame_q.size(), frame_q.size() - 1, miso, rise);
    exp_time = t;
    tests_run++;
    if (TIME_INIT !== exp_time || upd_pulses - upd0 !== 1) begin
      tests_failed++; $display("FAIL areset_recover: time %h pulses %0d want %h 1", TIME_INIT, upd_pulses - upd0, exp_time);
    end
    tests_run++;
    if (dut_rec !== exp_rec || ERR !== exp_err) begin
      tests_failed++; $display("FAIL areset_rec_hold: rec %h err %b want %h %b", dut_rec, ERR, exp_rec, exp_err);
    end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_record_basic();
    test_time_frame();
    test_bad_checksum();
    test_abort();
    test_unknown_and_status();
    test_trailing_bytes();
    test_random_frames();
    test_async_reset();
    tests_run++;
    if (both_high !== 0) begin tests_failed++; $display("FAIL strobe_overlap: got %0d cycles want 0", both_high); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
